fetch_unit: RTL

- Parametrised instruction-fetch stage; successor to the single-cycle fixed-16-bit fetch.
- Owns the PC register and issues requests to a variable-latency instruction memory (req/done handshake).
- Buffers one instruction for decode with a valid/ready handshake.
- Supports branch redirect with squash of in-flight fetches, and halt.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_out_buf.sv | 36 +++
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the fetch stage.
//   - fetch_state_t : fetch FSM encoding (FETCH, SQUASH, HALTED)
//   - *_DEF         : default widths and the sequential PC increment
//   - fetch_out_t   : ins/pc/pc_next bundle at the default widths
//   - sat_inc32     : saturating 32-bit increment for the statistics counters
package fetch_pkg;

    localparam int unsigned PC_W_DEF        = 16;
    localparam int unsigned INSTR_W_DEF     = 16;
    localparam int unsigned INSTR_BYTES_DEF = 2;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] ins;
        logic [PC_W_DEF-1:0]    pc;
        logic [PC_W_DEF-1:0]    pc_next;
    } fetch_out_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: one-entry valid/ready output register.
//   clk, rst : clock, synchronous active-high reset (clears valid and data)
//   load     : capture din and mark valid (wins over flush and consume)
//   flush    : drop the held entry
//   ready    : consumer accepts the entry this cycle when valid=1
//   din      : packed {ins, pc, pc_next}
//   valid    : entry held
//   dout     : held entry, stable while valid && !ready
module fetch_out_buf
    import fetch_pkg::*;
#(
    parameter int unsigned W = $bits(fetch_out_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         flush,
    input  logic         ready,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (flush || (valid && ready)) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: parametrised instruction-fetch stage.
// Owns the PC, issues req/done requests to a variable-latency instruction
// memory, and presents one buffered instruction to decode (valid/ready).
// Supports redirect (squashing an in-flight fetch) and a sticky halt.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   redirect, redirect_pc : load a new PC, drop buffered/in-flight work
//   halt                  : stop fetching until reset (beats redirect)
//   imem_req, imem_addr   : memory request; held stable until imem_done
//   imem_rdata, imem_done : returned instruction / completion strobe
//   ins_valid, ins, pc, pc_next, ins_ready : decode interface
//   halted                : FSM is in HALTED
//
// Build option: define FETCH_STATS_EN to add the saturating counters
//   stat_fetched (instructions delivered) and stat_stall (req && !done cycles).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEF,
    parameter int unsigned INSTR_W     = INSTR_W_DEF,
    parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_done,
    output logic               ins_valid,
    output logic [INSTR_W-1:0] ins,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_next,
    input  logic               ins_ready,
    output logic               halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_stall
`endif
);

    localparam int unsigned BUF_W = INSTR_W + 2 * PC_W;
    localparam logic [PC_W-1:0] PC_INC   = PC_W'(INSTR_BYTES);
    localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] sq_addr_q, sq_addr_d;
    logic            req_pend_q, req_pend_d;
    logic            halt_pend_q, halt_pend_d;
    logic            req_raw;
    logic            buf_load;
    logic            buf_flush;
    logic [PC_W-1:0] pc_inc;
    logic [BUF_W-1:0] buf_din;
    logic [BUF_W-1:0] buf_dout;

    assign pc_inc = pc_q + PC_INC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= PC_RESET;
            sq_addr_q   <= '0;
            req_pend_q  <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            sq_addr_q   <= sq_addr_d;
            req_pend_q  <= req_pend_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // A request raised in a redirect/halt cycle is already visible to memory,
    // so it is treated as outstanding and drained through SQUASH if not done.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sq_addr_d   = sq_addr_q;
        halt_pend_d = halt_pend_q;
        req_pend_d  = 1'b0;
        req_raw     = 1'b0;
        imem_addr   = pc_q;
        buf_load    = 1'b0;
        buf_flush   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                req_raw = req_pend_q || !ins_valid || ins_ready;
                if (halt) begin
                    buf_flush = 1'b1;
                    if (req_raw && !imem_done) begin
                        state_d     = ST_SQUASH;
                        halt_pend_d = 1'b1;
                        sq_addr_d   = pc_q;
                    end else begin
                        state_d = ST_HALTED;
                    end
                end else if (redirect) begin
                    buf_flush = 1'b1;
                    pc_d      = redirect_pc;
                    if (req_raw && !imem_done) begin
                        state_d   = ST_SQUASH;
                        sq_addr_d = pc_q;
                    end
                end else begin
                    req_pend_d = req_raw && !imem_done;
                    if (req_raw && imem_done) begin
                        buf_load = 1'b1;
                        pc_d     = pc_inc;
                    end
                end
            end
            ST_SQUASH: begin
                req_raw   = 1'b1;
                imem_addr = sq_addr_q;
                buf_flush = 1'b1;
                if (halt) begin
                    halt_pend_d = 1'b1;
                end else if (redirect && !halt_pend_q) begin
                    pc_d = redirect_pc;
                end
                if (imem_done) begin
                    state_d = (halt || halt_pend_q) ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                buf_flush = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // The reset cycle must not present a request; registers are already
    // forced by rst, so only the output needs gating.
    assign imem_req = req_raw && !rst;
    assign halted   = (state_q == ST_HALTED);
    assign buf_din  = {imem_rdata, pc_q, pc_inc};

    fetch_out_buf #(
        .W(BUF_W)
    ) u_out_buf (
        .clk  (clk),
        .rst  (rst),
        .load (buf_load),
        .flush(buf_flush),
        .ready(ins_ready),
        .din  (buf_din),
        .valid(ins_valid),
        .dout (buf_dout)
    );

    assign {ins, pc, pc_next} = buf_dout;

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_stall   <= '0;
        end else begin
            if (buf_load) begin
                stat_fetched <= sat_inc32(stat_fetched);
            end
            if (imem_req && !imem_done) begin
                stat_stall <= sat_inc32(stat_stall);
            end
        end
    end
`endif

endmodule
